// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: circular instruction queue between fetch and decode.
// Holds {instruction, pc, pc+4} triples, back-pressures fetch when full and
// drops every held entry on a control-flow redirect (flush).
module fetch_decode_queue #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  instruction_in,
  input  logic [31:0]                  pc_in,
  input  logic [31:0]                  pc_4_in,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  instruction_out,
  output logic [31:0]                  pc_out,
  output logic [31:0]                  pc_4_out,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Entry storage, one array per field.
  logic [31:0] inst_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] pc_4_mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic enq;
  logic deq;

  // Handshake flags depend on registered count only, so no path from
  // out_ready or flush reaches in_ready.
  assign in_ready  = (count_q != CNT_FULL);
  assign out_valid = (count_q != '0);
  assign occupancy = count_q;

  // A flush cycle neither stores the wrong-path fetch nor retires the head.
  assign enq = in_valid && in_ready && !flush;
  assign deq = out_valid && out_ready && !flush;

  // Next-state for pointers and count; flush overrides everything.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (deq) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (enq && !deq)      count_d = count_q + CNT_ONE;
      else if (deq && !enq) count_d = count_q - CNT_ONE;
    end
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry write at the write pointer on an accepted enqueue.
  always_ff @(posedge clock) begin
    // NOTE: the storage is deliberately not reset; count gates every read,
    // so stale contents are never visible and the array stays plain RAM.
    if (enq) begin
      inst_mem[wr_ptr_q] <= instruction_in;
      pc_mem[wr_ptr_q]   <= pc_in;
      pc_4_mem[wr_ptr_q] <= pc_4_in;
    end
  end

  // Head entry to decode, or a NOP with zero addresses when empty.
  always_comb begin
    instruction_out = NOP_INST;
    pc_out          = '0;
    pc_4_out        = '0;
    if (out_valid) begin
      instruction_out = inst_mem[rd_ptr_q];
      pc_out          = pc_mem[rd_ptr_q];
      pc_4_out        = pc_4_mem[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb_fetch_decode_queue: directed stimulus with a queue-based reference model
// compared every cycle, plus literal expectations at key points.
module tb_fetch_decode_queue;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction_in;
  logic [31:0] pc_in;
  logic [31:0] pc_4_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic [31:0] pc_4_out;
  logic [1:0]  occupancy;

  int n_vec  = 0;
  int n_miss = 0;

  fetch_decode_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clock           (clock),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .instruction_in  (instruction_in),
    .pc_in           (pc_in),
    .pc_4_in         (pc_4_in),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .instruction_out (instruction_out),
    .pc_out          (pc_out),
    .pc_4_out        (pc_4_out),
    .occupancy       (occupancy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of held entries.
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ent_t;
  ent_t mq[$];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mq.delete();
    end else begin
      bit was_full, was_empty;
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      if (flush) begin
        mq.delete();
      end else begin
        if (out_ready && !was_empty) void'(mq.pop_front());
        if (in_valid && !was_full)
          mq.push_back('{inst: instruction_in, pc: pc_in, pc4: pc_4_in});
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    int n;
    n = mq.size();
    check("m_out_valid", {31'b0, out_valid}, {31'b0, n != 0});
    check("m_in_ready",  {31'b0, in_ready},  {31'b0, n != DEPTH});
    check("m_occupancy", {30'b0, occupancy}, 32'(n));
    check("m_inst",      instruction_out, (n != 0) ? mq[0].inst : NOP);
    check("m_pc",        pc_out,          (n != 0) ? mq[0].pc   : 32'h0);
    check("m_pc4",       pc_4_out,        (n != 0) ? mq[0].pc4  : 32'h0);
  end

  // Apply one cycle of inputs, then wait to the following falling edge.
  task automatic drive(input logic iv, input logic [31:0] inst, input logic [31:0] pc,
                       input logic fl, input logic ordy);
    in_valid       = iv;
    instruction_in = inst;
    pc_in          = pc;
    pc_4_in        = pc + 32'd4;
    flush          = fl;
    out_ready      = ordy;
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; instruction_in = '0; pc_in = '0; pc_4_in = '0;
    flush = 1'b0; out_ready = 1'b0;
    @(negedge clock);

    // Reset held with fetch presenting an instruction.
    drive(1, 32'h00500093, 32'h0, 0, 0);
    drive(1, 32'h00500093, 32'h0, 0, 0);
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_in_ready",  {31'b0, in_ready},  32'h1);
    check("rst_inst",      instruction_out,    32'h00000013);
    check("rst_occ",       {30'b0, occupancy}, 32'h0);
    reset = 1'b0;
    drive(0, 32'h0, 32'h0, 0, 0);
    check("post_rst_occ",  {30'b0, occupancy}, 32'h0);

    // Streaming with decode always ready.
    drive(1, 32'h00500093, 32'h0, 0, 1);
    check("str0_pc",  pc_out, 32'h0);
    check("str0_occ", {30'b0, occupancy}, 32'h1);
    drive(1, 32'h00a00113, 32'h4, 0, 1);
    check("str1_pc",   pc_out, 32'h4);
    check("str1_inst", instruction_out, 32'h00a00113);
    check("str1_occ",  {30'b0, occupancy}, 32'h1);
    drive(1, 32'h002081b3, 32'h8, 0, 1);
    check("str2_pc",   pc_out, 32'h8);
    check("str2_pc4",  pc_4_out, 32'hc);
    check("str2_inst", instruction_out, 32'h002081b3);
    drive(0, 32'h0, 32'h0, 0, 1);
    check("str_drain", {30'b0, occupancy}, 32'h0);

    // Back-pressure: fill, try a third, then drain (full queue refuses
    // the enqueue even while it dequeues).
    drive(1, 32'h00500093, 32'h0, 0, 0);
    drive(1, 32'h00a00113, 32'h4, 0, 0);
    check("bp_occ",      {30'b0, occupancy}, 32'h2);
    check("bp_in_ready", {31'b0, in_ready},  32'h0);
    drive(1, 32'h002081b3, 32'h8, 0, 0);
    check("bp_hold_occ", {30'b0, occupancy}, 32'h2);
    check("bp_hold_pc",  pc_out, 32'h0);
    drive(1, 32'h002081b3, 32'h8, 0, 1);
    check("bp_deq_pc",   pc_out, 32'h4);
    check("bp_deq_occ",  {30'b0, occupancy}, 32'h1);
    check("bp_ready_up", {31'b0, in_ready},  32'h1);
    drive(0, 32'h0, 32'h0, 0, 1);
    check("bp_empty",    {30'b0, occupancy}, 32'h0);

    // Simultaneous enqueue and dequeue.
    drive(1, 32'h11111111, 32'h10, 0, 0);
    check("sim_occ0", {30'b0, occupancy}, 32'h1);
    drive(1, 32'h22222222, 32'h14, 0, 1);
    check("sim_occ1", {30'b0, occupancy}, 32'h1);
    check("sim_head", pc_out, 32'h14);
    drive(0, 32'h0, 32'h0, 0, 1);

    // Flush drops contents and the flush-cycle fetch.
    drive(1, 32'h33333333, 32'h20, 0, 0);
    drive(1, 32'h44444444, 32'h24, 0, 0);
    check("fl_pre_occ", {30'b0, occupancy}, 32'h2);
    drive(1, 32'h55555555, 32'h28, 1, 1);
    check("fl_occ",      {30'b0, occupancy}, 32'h0);
    check("fl_out_valid",{31'b0, out_valid}, 32'h0);
    check("fl_inst",     instruction_out,    32'h00000013);
    check("fl_in_ready", {31'b0, in_ready},  32'h1);
    drive(1, 32'h66666666, 32'h100, 0, 0);
    check("fl_tgt_pc",   pc_out, 32'h100);
    check("fl_tgt_valid",{31'b0, out_valid}, 32'h1);
    drive(0, 32'h0, 32'h0, 0, 1);

    // Wrap-around: seven pairs with alternating extra stalls.
    for (int i = 0; i < 7; i++) begin
      drive(1, 32'h1000_0000 + i, 32'(4 * i), 0, 0);
      check("wr_pc",  pc_out, 32'(4 * i));
      check("wr_occ", {30'b0, occupancy}, 32'h1);
      if (i % 2 == 0) begin
        drive(0, 32'h0, 32'h0, 0, 0);
        check("wr_stall_pc", pc_out, 32'(4 * i));
      end
      drive(0, 32'h0, 32'h0, 0, 1);
      check("wr_empty", {30'b0, occupancy}, 32'h0);
    end

    // Reset asserted in the middle of a flush/transfer cycle.
    drive(1, 32'h77777777, 32'h40, 0, 0);
    drive(1, 32'h88888888, 32'h44, 0, 0);
    in_valid = 1'b1; pc_in = 32'h48; pc_4_in = 32'h4c; flush = 1'b1; out_ready = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("mid_rst_occ",   {30'b0, occupancy}, 32'h0);
    check("mid_rst_valid", {31'b0, out_valid}, 32'h0);
    check("mid_rst_ready", {31'b0, in_ready},  32'h1);
    @(negedge clock);
    reset = 1'b0;
    drive(0, 32'h0, 32'h0, 0, 0);
    check("after_mid_rst", {30'b0, occupancy}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
- Small instruction queue between the fetch stage and the decode stage.
- Captures each fetched {instruction, pc, pc+4} triple and presents it to decode with a valid/ready handshake.
- Back-pressures fetch when full, so the PC holds while decode stalls.
- Discards all wrong-path entries on a control-flow redirect (branch/JAL/JALR taken).

Parameters:
- DEPTH, 2, number of queue entries; power of two, minimum 2.
- NOP_INST, 32'h0000_0013, instruction driven on instruction_out when the queue is empty (addi x0,x0,0).

Ports:
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- in_valid  input  1  fetch presents a valid instruction this cycle
- in_ready  output  1  queue can accept; fetch must hold PC when low
- instruction_in  input  32 (word)  fetched instruction
- pc_in  input  32 (word)  address of instruction_in
- pc_4_in  input  32 (word)  pc_in + 4
- flush  input  1  redirect taken this cycle; invalidates queue contents
- out_valid  output  1  head entry is valid for decode
- out_ready  input  1  decode consumes head entry this cycle
- instruction_out  output  32 (word)  head instruction, or NOP_INST when empty
- pc_out  output  32 (word)  head pc, or 0 when empty
- pc_4_out  output  32 (word)  head pc+4, or 0 when empty
- occupancy  output  $clog2(DEPTH+1)  current entry count

Behaviour:
- Storage:
  - DEPTH entries of {instruction, pc, pc_4}, circular buffer.
  - Read pointer and write pointer, each $clog2(DEPTH) bits, wrap modulo DEPTH.
  - Count register, $clog2(DEPTH+1) bits.
- Reset (async assert):
  - count=0, pointers=0; entry contents don't-care.
  - Outputs while in reset: out_valid=0, in_ready=1, instruction_out=NOP_INST, pc_out=0, pc_4_out=0, occupancy=0.
  - Reset deassertion is synchronous to clock at the system level; no special handling in this block.
- Handshake and control:
  - in_ready = (count != DEPTH). Registered-state only; no combinational path from out_ready or flush.
  - out_valid = (count != 0).
  - Enqueue when in_valid && in_ready && !flush: write entry at write pointer, then increment write pointer.
  - Dequeue when out_valid && out_ready && !flush: increment read pointer.
  - Simultaneous enqueue and dequeue: both pointers advance, count unchanged.
  - A full queue does not accept in the same cycle it dequeues; in_ready stays low for that cycle.
- Latency:
  - An entry enqueued at edge N appears on the outputs after edge N.
  - Minimum fetch-to-decode latency is 1 cycle. No combinational bypass when empty.
- Outputs:
  - instruction_out, pc_out and pc_4_out are muxed from the head entry when count != 0.
  - Otherwise they are NOP_INST, 0 and 0.
- Flush:
  - Synchronous. At the edge where flush=1: count=0, read pointer = write pointer = 0.
  - The in_valid data presented in the flush cycle is dropped (wrong path).
  - Any out_ready in the flush cycle is ignored.
  - Flush has priority over enqueue and dequeue.
  - The cycle after flush: out_valid=0, in_ready=1; the target instruction can enqueue.
- Boundary conditions:
  - Enqueue while full: ignored, no overwrite (in_ready=0 makes this illegal; the queue still protects itself).
  - Dequeue while empty: ignored.
  - Pointer wrap from DEPTH-1 to 0 is seamless.
  - Reset mid-flush or mid-transfer: reset wins, state returns to the reset values.

Test Plan:
- Reset: hold reset, drive in_valid=1 with instruction 32'h00500093 -> out_valid=0, in_ready=1, instruction_out=32'h00000013, occupancy=0. After release: no entry from the reset cycles.
- Streaming: out_ready=1; enqueue pc=0x0,0x4,0x8 (instructions 0x00500093, 0x00a00113, 0x002081b3) on consecutive cycles -> each appears one cycle later in order. occupancy stays 1; pc_4_out = pc_out+4.
- Back-pressure: out_ready=0, enqueue pc=0x0,0x4 -> occupancy=2, in_ready=0; a third in_valid at pc=0x8 is not stored. Raise out_ready -> pc 0x0 then 0x4 out, and in_ready returns 1 the cycle after the first dequeue.
- Simultaneous: queue holds pc=0x10 with count=1; in the same cycle enqueue pc=0x14 and dequeue -> occupancy stays 1, head becomes 0x14.
- Flush: queue holds pc=0x20,0x24; assert flush with in_valid=1 at pc=0x28 -> next cycle occupancy=0, out_valid=0, instruction_out=NOP. Enqueue target pc=0x100 -> appears next cycle.
- Wrap-around: with DEPTH=2, run 7 enqueue/dequeue pairs with pc=0x0..0x18 and alternating stalls -> output order exact, no loss or duplication across pointer wrap.
